// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and an idle cycle inserts a bubble.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            stall,
   input  logic            load,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] pc_plus4_in,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus4_out,
   output logic            valid_out
);

   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic            valid_q, valid_d;

   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (flush || (!stall && !load)) begin
         instr_d    = NOP_INSTR;
         pc_d       = '0;
         pc_plus4_d = '0;
         valid_d    = 1'b0;
      end else if (!stall) begin
         instr_d    = instr_in;
         pc_d       = pc_in;
         pc_plus4_d = pc_plus4_in;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_out    = instr_q;
   assign pc_out       = pc_q;
   assign pc_plus4_out = pc_plus4_q;
   assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PCF, runs a single-outstanding imem request FSM and feeds the IF/ID register.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
   parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            flushD,
   input  logic            PC_srcE,
   input  logic [XLEN-1:0] PC_targetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PC_plus4D,
   output logic            validD,
   output logic            fetch_busy
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pcf_q, pcf_d;
   logic [XLEN-1:0] pend_addr_q, pend_addr_d;
   logic [31:0]     buf_q, buf_d;

   logic            advance;
   logic [XLEN-1:0] pcf_plus4;
   logic            ifid_load;
   logic            ifid_hold;
   logic [31:0]     ifid_instr;

   assign advance   = !(stallF || stallD);
   assign pcf_plus4 = pcf_q + XLEN'(4);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         pcf_q   <= RESET_PC;
      end else begin
         state_q <= state_d;
         pcf_q   <= pcf_d;
      end
   end

   always_ff @(posedge clk) begin
      pend_addr_q <= pend_addr_d;
      buf_q       <= buf_d;
   end

   always_comb begin
      state_d     = state_q;
      pcf_d       = pcf_q;
      pend_addr_d = pend_addr_q;
      buf_d       = buf_q;
      ifid_load   = 1'b0;
      ifid_hold   = 1'b0;
      ifid_instr  = imem_rdata;
      case (state_q)
         ST_FETCH: begin
            // An unacked request must still be drained, so remember where it went.
            if (PC_srcE) begin
               pcf_d = PC_targetE;
               if (!imem_ack) begin
                  pend_addr_d = pcf_q;
                  state_d     = ST_DISCARD;
               end
            end else if (imem_ack && advance) begin
               ifid_load = 1'b1;
               pcf_d     = pcf_plus4;
            end else if (imem_ack) begin
               buf_d     = imem_rdata;
               ifid_hold = 1'b1;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            ifid_instr = buf_q;
            if (PC_srcE) begin
               pcf_d   = PC_targetE;
               state_d = ST_FETCH;
            end else if (advance) begin
               ifid_load = 1'b1;
               pcf_d     = pcf_plus4;
               state_d   = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            if (PC_srcE) begin
               pcf_d = PC_targetE;
            end
            if (imem_ack) begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      imem_req   = reset && ((state_q == ST_FETCH) || (state_q == ST_DISCARD));
      imem_addr  = (state_q == ST_DISCARD) ? pend_addr_q : pcf_q;
      fetch_busy = (state_q == ST_DISCARD) || ((state_q == ST_FETCH) && !imem_ack);
   end

   if_id_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk          (clk),
      .reset        (reset),
      .flush        (flushD || PC_srcE),
      .stall        (stallD || ifid_hold),
      .load         (ifid_load),
      .instr_in     (ifid_instr),
      .pc_in        (pcf_q),
      .pc_plus4_in  (pcf_plus4),
      .instr_out    (instrD),
      .pc_out       (PCD),
      .pc_plus4_out (PC_plus4D),
      .valid_out    (validD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage with a reactive zero/multi-wait instruction memory.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallF, stallD, flushD, PC_srcE;
   logic [31:0] PC_targetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instrD;
   logic [31:0] PCD, PC_plus4D;
   logic        validD;
   logic        fetch_busy;

   logic        ack_en;
   logic        use_ovr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] w(input logic [31:0] a);
      return {16'hCAFE, a[15:0]};
   endfunction

   assign imem_ack   = ack_en & imem_req;
   assign imem_rdata = use_ovr ? 32'hAAAA_AAAA : w(imem_addr);

   fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .stallF     (stallF),
      .stallD     (stallD),
      .flushD     (flushD),
      .PC_srcE    (PC_srcE),
      .PC_targetE (PC_targetE),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instrD     (instrD),
      .PCD        (PCD),
      .PC_plus4D  (PC_plus4D),
      .validD     (validD),
      .fetch_busy (fetch_busy)
   );

   typedef struct {
      logic        rst;
      logic        sf, sd, fd, src;
      logic [31:0] tgt;
      logic        ackm, ovr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_busy;
      logic [31:0] e_instr, e_pcd, e_p4;
      logic        e_vld;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, sf, sd, fd, src, input logic [31:0] tgt,
                      input logic ackm, ovr, input logic e_req, input logic [31:0] e_addr,
                      input logic e_busy, input logic [31:0] e_instr, e_pcd, e_p4,
                      input logic e_vld);
      vec_t v;
      v.rst = rst; v.sf = sf; v.sd = sd; v.fd = fd; v.src = src; v.tgt = tgt;
      v.ackm = ackm; v.ovr = ovr; v.e_req = e_req; v.e_addr = e_addr; v.e_busy = e_busy;
      v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_p4 = e_p4; v.e_vld = e_vld;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [row %0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
      end
   endtask

   initial begin
      bit found;
      //   rst sf sd fd src tgt            ack ovr req addr          busy instr             pcd           p4            vld
      add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,         1, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h0,         0, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h4,         0, w(32'h0),         32'h0,        32'h4,        1);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h8,         0, w(32'h4),         32'h4,        32'h8,        1);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'hC,         0, w(32'h8),         32'h8,        32'hC,        1);
      add(1, 0, 0, 0, 0, 32'h0,          0, 0, 1, 32'h10,        1, w(32'hC),         32'hC,        32'h10,       1);
      add(1, 0, 0, 0, 0, 32'h0,          0, 0, 1, 32'h10,        1, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h10,        0, NOP,              32'h0,        32'h0,        0);
      add(1, 1, 1, 0, 0, 32'h0,          1, 1, 1, 32'h14,        0, w(32'h10),        32'h10,       32'h14,       1);
      add(1, 1, 1, 0, 0, 32'h0,          1, 0, 0, 32'h14,        0, w(32'h10),        32'h10,       32'h14,       1);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h14,        0, w(32'h10),        32'h10,       32'h14,       1);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h18,        0, 32'hAAAA_AAAA,    32'h14,       32'h18,       1);
      add(1, 0, 0, 1, 1, 32'h180,        0, 0, 1, 32'h1C,        1, w(32'h18),        32'h18,       32'h1C,       1);
      add(1, 0, 0, 1, 1, 32'h100,        0, 0, 1, 32'h1C,        1, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h1C,        1, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h100,       0, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 1, 1, 32'h200,        1, 0, 1, 32'h104,       0, w(32'h100),       32'h100,      32'h104,      1);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h200,       0, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 1, 1, 0, 32'h0,          1, 0, 1, 32'h204,       0, w(32'h200),       32'h200,      32'h204,      1);
      add(1, 1, 1, 0, 0, 32'h0,          1, 0, 0, 32'h204,       0, NOP,              32'h0,        32'h0,        0);
      add(0, 0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h204,       0, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h0,         0, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 1, 1, 32'hFFFF_FFFC,  1, 0, 1, 32'h4,         0, w(32'h0),         32'h0,        32'h4,        1);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'hFFFF_FFFC, 0, NOP,              32'h0,        32'h0,        0);
      add(1, 0, 0, 0, 0, 32'h0,          1, 0, 1, 32'h0,         0, w(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0,       1);

      reset = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
      PC_srcE = 1'b0; PC_targetE = '0; ack_en = 1'b0; use_ovr = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset = vecs[i].rst; stallF = vecs[i].sf; stallD = vecs[i].sd;
         flushD = vecs[i].fd; PC_srcE = vecs[i].src; PC_targetE = vecs[i].tgt;
         ack_en = vecs[i].ackm; use_ovr = vecs[i].ovr;
         #1;
         check("imem_req",   i, 32'(imem_req),   32'(vecs[i].e_req));
         check("imem_addr",  i, imem_addr,       vecs[i].e_addr);
         check("fetch_busy", i, 32'(fetch_busy), 32'(vecs[i].e_busy));
         check("instrD",     i, instrD,          vecs[i].e_instr);
         check("PCD",        i, PCD,             vecs[i].e_pcd);
         check("PC_plus4D",  i, PC_plus4D,       vecs[i].e_p4);
         check("validD",     i, 32'(validD),     32'(vecs[i].e_vld));
      end

      // Reset while a request to 0x4 is outstanding: no stale response may surface.
      @(negedge clk);
      reset = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; PC_srcE = 1'b0;
      ack_en = 1'b0; use_ovr = 1'b0;
      #1;
      check("req_in_reset", 100, 32'(imem_req), 32'h0);
      @(negedge clk);
      reset = 1'b1; ack_en = 1'b1;
      #1;
      check("addr_after_reset",  101, imem_addr, 32'h0);
      check("instr_after_reset", 101, instrD,    NOP);
      found = 1'b0;
      for (int k = 0; k < 5 && !found; k++) begin
         @(negedge clk);
         #1;
         if (validD) found = 1'b1;
      end
      check("validD_timeout", 102, 32'(found), 32'h1);
      check("first_pcd",      102, PCD,        32'h0);
      check("first_instr",    102, instrD,     w(32'h0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
